// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Lets the instruction-fetch requester and the load/store requester share one
// sram-like memory port. Only one transaction is in flight at a time. When both
// sides ask in the same cycle, the side that did not win last time gets the port.
// A response goes only to the side that owns the transaction. A flush suppresses
// delivery of a pending instruction response, but the memory access itself still
// runs to completion.

module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,

    // instruction-fetch side
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    // load/store side
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    // memory bridge side
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    state_t state_q, state_d;

    // Control registers
    logic owner_q, owner_d;
    logic last_grant_q, last_grant_d;
    logic cancel_q, cancel_d;

    // Request fields captured at grant time; they drive the memory port
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Arbitration results
    logic inst_win;
    logic data_win;
    logic grant_inst;
    logic grant_data;
    logic resp_fire;

    // A lone requester always wins; on a tie the side opposite to last_grant wins.
    // With last_grant reset to inst, data takes the first tie after reset.
    assign inst_win   = inst_req & (~data_req | (last_grant_q == OWNER_DATA));
    assign data_win   = data_req & (~inst_req | (last_grant_q == OWNER_INST));

    // Grants are only handed out while the port is free.
    assign grant_inst = (state_q == IDLE) & inst_win;
    assign grant_data = (state_q == IDLE) & data_win;

    // The memory response that closes the current transaction.
    assign resp_fire  = (state_q == RESP) & mem_data_ok;

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_inst || grant_data) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A response arriving before the request is accepted is
                // illegal from the bridge and is deliberately ignored here.
                if (mem_addr_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ownership and round-robin history follow each grant
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        if (grant_data) begin
            owner_d      = OWNER_DATA;
            last_grant_d = OWNER_DATA;
        end else if (grant_inst) begin
            owner_d      = OWNER_INST;
            last_grant_d = OWNER_INST;
        end
    end

    // Capture the winning request so the memory port stays stable until accepted
    always_comb begin
        wr_d    = wr_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant_data) begin
            wr_d    = data_wr;
            size_d  = data_size;
            wstrb_d = data_wstrb;
            addr_d  = data_addr;
            wdata_d = data_wdata;
        end else if (grant_inst) begin
            // Fetches are always word reads.
            wr_d    = 1'b0;
            size_d  = 2'd2;
            wstrb_d = 4'h0;
            addr_d  = inst_addr;
            wdata_d = '0;
        end
    end

    // Track whether a flush has made the pending instruction response stale
    always_comb begin
        cancel_d = cancel_q;
        if (grant_inst || grant_data) begin
            // A flush in the same cycle as a fetch grant already kills that fetch.
            cancel_d = grant_inst & flush;
        end else if (state_q == REQ) begin
            if ((owner_q == OWNER_INST) && flush) begin
                cancel_d = 1'b1;
            end
        end else if (state_q == RESP) begin
            if (mem_data_ok) begin
                cancel_d = 1'b0;
            end else if ((owner_q == OWNER_INST) && flush) begin
                cancel_d = 1'b1;
            end
        end
    end

    // State and captured request fields; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_INST;
            last_grant_q <= OWNER_INST;
            cancel_q     <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            wstrb_q      <= 4'h0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cancel_q     <= cancel_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Handshakes back to the requesters. The acceptance strobes are gated with
    // resetn so a request held high during reset is never acknowledged. A flush
    // coinciding with the response suppresses it in that same cycle.
    assign inst_addr_ok = resetn & grant_inst;
    assign data_addr_ok = resetn & grant_data;
    assign data_data_ok = resetn & resp_fire & (owner_q == OWNER_DATA);
    assign inst_data_ok = resetn & resp_fire & (owner_q == OWNER_INST) & ~cancel_q & ~flush;

    // Read data is a straight pass-through; it only matters alongside data_ok.
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Memory request: asserted only while waiting for acceptance.
    assign mem_req      = (state_q == REQ);
    assign mem_wr       = wr_q;
    assign mem_size     = size_q;
    assign mem_wstrb    = wstrb_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Expected responses are queued when a
// request is granted and popped when the DUT raises a data_ok.

module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } resp_t;

    resp_t sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare any response the DUT shows this cycle against the scoreboard
    task automatic sample_resp();
        resp_t e;
        if (inst_data_ok || data_data_ok) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 128'({inst_data_ok, data_data_ok}), 128'(2'b00));
            end else begin
                e = sb_q.pop_front();
                chk("resp_side", 128'({inst_data_ok, data_data_ok}), 128'(e.is_data ? 2'b01 : 2'b10));
                chk("resp_rdata", 128'(e.is_data ? data_rdata : inst_rdata), 128'(e.rdata));
            end
        end
    endtask

    task automatic reset_dut();
        resetn      = 1'b0;
        flush       = 1'b0;
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Grant cycle in IDLE: check who is accepted, then advance
    task automatic grant(input logic exp_i, input logic exp_d);
        @(negedge clk);
        chk("inst_addr_ok", 128'(inst_addr_ok), 128'(exp_i));
        chk("data_addr_ok", 128'(data_addr_ok), 128'(exp_d));
        chk("mem_req_idle", 128'(mem_req), 128'(1'b0));
        sample_resp();
        tick();
    endtask

    // Play the memory side from REQ entry to the response, checking port stability
    task automatic serve(input int addr_dly, input int data_dly, input logic [31:0] rdata,
                         input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i <= addr_dly; i++) begin
            mem_addr_ok = (i == addr_dly);
            @(negedge clk);
            chk("mem_req", 128'(mem_req), 128'(1'b1));
            chk("mem_fields", 128'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}),
                128'({wr, size, wstrb, addr, wdata}));
            chk("addr_ok_busy", 128'({inst_addr_ok, data_addr_ok}), 128'(2'b00));
            sample_resp();
            tick();
        end
        mem_addr_ok = 1'b0;
        for (int i = 0; i <= data_dly; i++) begin
            mem_data_ok = (i == data_dly);
            mem_rdata   = (i == data_dly) ? rdata : ~rdata;
            @(negedge clk);
            chk("mem_req_resp", 128'(mem_req), 128'(1'b0));
            sample_resp();
            tick();
        end
        mem_data_ok = 1'b0;
        chk("resp_missing", 128'(sb_q.size()), 128'(0));
    endtask

    // Fetch whose response must be dropped; when: 0 = flush with grant, 1 = in REQ, 2 = with response
    task automatic inst_flushed(input int when, input logic [31:0] a);
        inst_req  = 1'b1;
        inst_addr = a;
        flush     = (when == 0);
        @(negedge clk);
        chk("fl_inst_addr_ok", 128'(inst_addr_ok), 128'(1'b1));
        tick();
        inst_req    = 1'b0;
        flush       = (when == 1);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("fl_mem_addr", 128'({mem_req, mem_addr}), 128'({1'b1, a}));
        tick();
        mem_addr_ok = 1'b0;
        flush       = (when == 2);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hBAD0_0000 | 32'(when);
        @(negedge clk);
        chk("fl_inst_data_ok", 128'(inst_data_ok), 128'(1'b0));
        sample_resp();
        tick();
        mem_data_ok = 1'b0;
        flush       = 1'b0;
    endtask

    logic        rr_d;
    logic [31:0] rr_a;
    logic [31:0] rr_wd;

    initial begin
        resetn      = 1'b0;
        flush       = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h0;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;

        // Reset state, with both requests held high to exercise the gating
        @(negedge clk);
        chk("rst_addr_ok", 128'({inst_addr_ok, data_addr_ok}), 128'(2'b00));
        chk("rst_data_ok", 128'({inst_data_ok, data_data_ok}), 128'(2'b00));
        chk("rst_mem", 128'({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}), 128'(0));
        reset_dut();

        // Single data read, best-case timing
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h0000_1000;
        grant(1'b0, 1'b1);
        data_req = 1'b0;
        sb_q.push_back({1'b1, 32'hDEAD_BEEF});
        serve(0, 0, 32'hDEAD_BEEF, 1'b0, 2'd2, 4'h0, 32'h0000_1000, 32'h0);

        // Round-robin with both sides held high: data, inst, data, inst
        reset_dut();
        inst_addr  = 32'hBFC0_0100;
        data_addr  = 32'h0000_8000;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_wstrb = 4'hF;
        data_wdata = 32'hA5A5_0000;
        inst_req   = 1'b1;
        data_req   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rr_d  = (k % 2 == 0);
            rr_a  = rr_d ? data_addr : inst_addr;
            rr_wd = rr_d ? data_wdata : 32'h0;
            grant(~rr_d, rr_d);
            if (rr_d) begin
                data_addr  = data_addr + 32'h4;
                data_wdata = data_wdata + 32'h1;
            end else begin
                inst_addr = inst_addr + 32'h4;
            end
            sb_q.push_back({rr_d, 32'h100 + 32'(k)});
            if (rr_d)
                serve(0, 0, 32'h100 + 32'(k), 1'b1, 2'd2, 4'hF, rr_a, rr_wd);
            else
                serve(0, 0, 32'h100 + 32'(k), 1'b0, 2'd2, 4'h0, rr_a, 32'h0);
        end
        inst_req = 1'b0;
        data_req = 1'b0;

        // Store with mem_addr_ok delayed 3 cycles; requester fields change after grant
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_wstrb = 4'hC;
        data_addr  = 32'h0000_2004;
        data_wdata = 32'h1234_5678;
        grant(1'b0, 1'b1);
        data_req   = 1'b0;
        data_addr  = 32'hFFFF_FFFC;
        data_wdata = 32'h0;
        data_wstrb = 4'h0;
        sb_q.push_back({1'b1, 32'h0000_0000});
        serve(3, 0, 32'h0000_0000, 1'b1, 2'd1, 4'hC, 32'h0000_2004, 32'h1234_5678);

        // Fetch flushed in RESP, response two cycles later must be dropped
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        grant(1'b1, 1'b0);
        inst_req    = 1'b0;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("f4_mem_addr", 128'({mem_req, mem_addr}), 128'({1'b1, 32'hBFC0_0000}));
        tick();
        mem_addr_ok = 1'b0;
        flush       = 1'b1;
        @(negedge clk);
        chk("f4_no_resp_flush", 128'(inst_data_ok), 128'(1'b0));
        tick();
        flush = 1'b0;
        @(negedge clk);
        sample_resp();
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_1111;
        @(negedge clk);
        chk("f4_inst_data_ok", 128'(inst_data_ok), 128'(1'b0));
        sample_resp();
        tick();
        mem_data_ok = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0004;
        grant(1'b1, 1'b0);
        inst_req = 1'b0;
        sb_q.push_back({1'b0, 32'h2402_0001});
        serve(0, 0, 32'h2402_0001, 1'b0, 2'd2, 4'h0, 32'hBFC0_0004, 32'h0);

        // Flush at grant, in REQ, and coinciding with the response
        inst_flushed(0, 32'hBFC0_0010);
        inst_flushed(1, 32'hBFC0_0020);
        inst_flushed(2, 32'hBFC0_0030);
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0040;
        grant(1'b1, 1'b0);
        inst_req = 1'b0;
        sb_q.push_back({1'b0, 32'h0000_0040});
        serve(0, 0, 32'h0000_0040, 1'b0, 2'd2, 4'h0, 32'hBFC0_0040, 32'h0);

        // Flush held through a data transaction: response still delivered
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd0;
        data_wstrb = 4'h0;
        data_addr = 32'h0000_0033;
        flush     = 1'b1;
        grant(1'b0, 1'b1);
        data_req = 1'b0;
        sb_q.push_back({1'b1, 32'hCAFE_F00D});
        serve(1, 1, 32'hCAFE_F00D, 1'b0, 2'd0, 4'h0, 32'h0000_0033, 32'h0);
        flush = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0050;
        grant(1'b1, 1'b0);
        inst_req = 1'b0;
        sb_q.push_back({1'b0, 32'h0000_0050});
        serve(0, 0, 32'h0000_0050, 1'b0, 2'd2, 4'h0, 32'hBFC0_0050, 32'h0);

        // Reset asserted in RESP, then a stray response, then normal operation
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h0000_3000;
        grant(1'b0, 1'b1);
        data_req    = 1'b0;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        tick();
        mem_addr_ok = 1'b0;
        resetn      = 1'b0;
        data_req    = 1'b1;
        inst_req    = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h5555_5555;
        #1;
        chk("mid_rst_addr_ok", 128'({inst_addr_ok, data_addr_ok}), 128'(2'b00));
        chk("mid_rst_data_ok", 128'({inst_data_ok, data_data_ok}), 128'(2'b00));
        chk("mid_rst_mem", 128'({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}), 128'(0));
        tick();
        resetn      = 1'b1;
        data_req    = 1'b0;
        inst_req    = 1'b0;
        mem_data_ok = 1'b1;
        @(negedge clk);
        chk("stray_data_ok", 128'({inst_data_ok, data_data_ok, mem_req}), 128'(3'b000));
        sample_resp();
        tick();
        mem_data_ok = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h0000_4000;
        grant(1'b0, 1'b1);
        data_req = 1'b0;
        sb_q.push_back({1'b1, 32'h0BAD_CAFE});
        serve(0, 0, 32'h0BAD_CAFE, 1'b0, 2'd2, 4'h0, 32'h0000_4000, 32'h0);

        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
